branch_redirect_ctrl: RTL and testbench
=======================================

Name: branch_redirect_ctrl

Overview:
Sequencer around the decode-stage jump unit. It waits for the operands of a decode-stage branch/jump to become valid, stalling fetch and decode meanwhile. It then registers the resolved target, issues a one-cycle PC redirect to fetch, and squashes the wrong-path instruction in decode. It sits between the jump unit/hazard unit and the fetch-stage PC mux.

Parameters:
MAX_WAIT, 4, operand-wait cycles after which the sticky hazard_timeout flag sets (range 1..255).
PC_WIDTH, 32, width of jump_address/redirect_pc.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
dec_valid  in  1  decode holds a valid instruction
dec_is_ctrl  in  1  decode instruction is a branch/jump (any type)
dec_uses_rs  in  1  control decision/target reads rs
dec_uses_rt  in  1  control decision reads rt
rs_pending  in  1  rs producer in flight, not yet forwardable
rt_pending  in  1  rt producer in flight, not yet forwardable
pc_src  in  1  jump unit take decision
jump_address  in  PC_WIDTH  jump unit target
stall_fetch  out  1  hold PC and the fetch/decode register
stall_decode  out  1  insert bubble into execute, hold decode
flush_decode  out  1  squash instruction currently in decode
redirect_valid  out  1  one-cycle pulse: load redirect_pc into PC
redirect_pc  out  PC_WIDTH  registered target
busy  out  1  FSM not in IDLE
hazard_timeout  out  1  sticky: operand wait reached MAX_WAIT

Behaviour:
- Reset (async, any state, mid-operation included): state=IDLE, wait_cnt=0, redirect_pc=0, hazard_timeout=0. All outputs 0 while reset is asserted and in the first cycle after release.
- need = (dec_uses_rs & rs_pending) | (dec_uses_rt & rt_pending).
- ctrl = dec_valid & dec_is_ctrl.
- States: IDLE, WAIT_OPS, REDIRECT (2-bit encoding).
- IDLE:
  - ctrl & need: stall_fetch = stall_decode = 1 combinationally in the same cycle; next state WAIT_OPS; wait_cnt <= 1.
  - ctrl & !need & pc_src: resolve; redirect_pc <= jump_address; next state REDIRECT.
  - ctrl & !need & !pc_src: no action; stay in IDLE.
- WAIT_OPS:
  - !dec_valid (external flush): return to IDLE with no redirect; wait_cnt <= 0.
  - need: stalls held at 1; wait_cnt increments and saturates at 255. When wait_cnt == MAX_WAIT, hazard_timeout <= 1 (sticky until reset); waiting continues.
  - !need: stalls drop to 0 this cycle; resolve exactly as IDLE does (REDIRECT if pc_src, else IDLE); wait_cnt <= 0.
- REDIRECT (exactly one cycle):
  - redirect_valid = 1 and flush_decode = 1 (Moore outputs).
  - Decode inputs are ignored; no stall is asserted.
  - Next state IDLE unconditionally.
- Latency: resolve in cycle N, redirect_valid in N+1, first target instruction in decode at N+2. Minimum spacing between two taken redirects is 2 cycles.
- Stalls are never asserted in the same cycle as redirect_valid.
- pc_src is sampled only in the resolve cycle, never while need = 1.

Optional Feature:
BRANCH_DELAY_SLOT_EN
- Defined: flush_decode is never asserted. The REDIRECT-cycle decode instruction is the delay slot and executes. If that instruction is itself a control instruction, its transfer is suppressed (the FSM ignores it).
- Undefined: flush_decode = 1 in REDIRECT, as described above.
- Both builds: redirect timing is identical.

Test Plan:
- Taken, no hazard: cycle N ctrl=1, need=0, pc_src=1, jump_address=0x0040_0100 -> N+1: redirect_valid=1, redirect_pc=0x0040_0100, flush_decode=1 (macro off); N+2: busy=0, all pulses 0.
- Not taken: ctrl=1, need=0, pc_src=0 -> no stall, no redirect, busy stays 0.
- Operand wait: rs_pending=1 for 3 cycles with dec_uses_rs=1, then 0 with pc_src=1, target 0x0000_2000 -> stalls high exactly 3 cycles; redirect_valid pulses the cycle after release; hazard_timeout=0 (MAX_WAIT=4).
- Timeout: rt_pending held 6 cycles, MAX_WAIT=4 -> hazard_timeout sets after the 4th stalled cycle and stays 1 after the wait ends, until reset.
- Reset mid-wait: assert reset in the 2nd WAIT_OPS cycle -> stalls, busy and redirect_valid go 0 immediately; after release the FSM is IDLE and no redirect fires.
- Back-to-back / delay slot: a second taken ctrl presented during the REDIRECT cycle is ignored in both builds. Macro defined -> flush_decode never asserted.

Source files
------------

// File: rtl/branch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : branch_redirect_ctrl
// Description : Decode-stage branch sequencer. It stalls fetch/decode until
//               the branch operands are forwardable, registers the resolved
//               target and issues a one-cycle PC redirect to fetch.
//               Optional build macro: BRANCH_DELAY_SLOT_EN (no decode squash).
// Revision    : 1.0 - initial release
// ============================================================================
module branch_redirect_ctrl #(
   parameter int MAX_WAIT = 4,
   parameter int PC_WIDTH = 32
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                dec_valid,
   input  logic                dec_is_ctrl,
   input  logic                dec_uses_rs,
   input  logic                dec_uses_rt,
   input  logic                rs_pending,
   input  logic                rt_pending,
   input  logic                pc_src,
   input  logic [PC_WIDTH-1:0] jump_address,
   output logic                stall_fetch,
   output logic                stall_decode,
   output logic                flush_decode,
   output logic                redirect_valid,
   output logic [PC_WIDTH-1:0] redirect_pc,
   output logic                busy,
   output logic                hazard_timeout
);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_OPS = 2'd1,
      ST_REDIRECT = 2'd2
   } state_t;

   localparam logic [7:0] c_max_wait = 8'(MAX_WAIT);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [7:0]          r_wait_cnt;
   logic [7:0]          w_wait_cnt_nxt;
   logic [PC_WIDTH-1:0] r_redirect_pc;
   logic                r_timeout;
   logic                r_live;
   logic                w_need;
   logic                w_ctrl;
   logic                w_stall;
   logic                w_load_pc;

   assign w_need = (dec_uses_rs & rs_pending) | (dec_uses_rt & rt_pending);
   assign w_ctrl = dec_valid & dec_is_ctrl;

   // r_live keeps the FSM inert (and every output low) for the first cycle
   // after reset release, so no stall can be raised on a half-reset pipeline.
   always_comb begin
      w_state_nxt    = r_state;
      w_wait_cnt_nxt = r_wait_cnt;
      w_stall        = 1'b0;
      w_load_pc      = 1'b0;
      if (r_live) begin
         case (r_state)
            ST_IDLE: begin
               if (w_ctrl && w_need) begin
                  w_stall        = 1'b1;
                  w_state_nxt    = ST_WAIT_OPS;
                  w_wait_cnt_nxt = 8'd1;
               end else if (w_ctrl && pc_src) begin
                  w_load_pc   = 1'b1;
                  w_state_nxt = ST_REDIRECT;
               end
            end
            ST_WAIT_OPS: begin
               if (!dec_valid) begin
                  w_state_nxt    = ST_IDLE;
                  w_wait_cnt_nxt = 8'd0;
               end else if (w_need) begin
                  w_stall        = 1'b1;
                  w_wait_cnt_nxt = (r_wait_cnt == 8'hFF) ? r_wait_cnt : r_wait_cnt + 8'd1;
               end else begin
                  w_wait_cnt_nxt = 8'd0;
                  if (pc_src) begin
                     w_load_pc   = 1'b1;
                     w_state_nxt = ST_REDIRECT;
                  end else begin
                     w_state_nxt = ST_IDLE;
                  end
               end
            end
            ST_REDIRECT: w_state_nxt = ST_IDLE;
            default:     w_state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_wait_cnt    <= 8'd0;
         r_redirect_pc <= '0;
         r_timeout     <= 1'b0;
         r_live        <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= w_wait_cnt_nxt;
         r_live     <= 1'b1;
         if (w_load_pc) begin
            r_redirect_pc <= jump_address;
         end
         // Wait count equals stalled cycles so far; flag at the end of stall MAX_WAIT.
         if (w_stall && (w_wait_cnt_nxt == c_max_wait)) begin
            r_timeout <= 1'b1;
         end
      end
   end

   assign stall_fetch    = w_stall;
   assign stall_decode   = w_stall;
   assign redirect_valid = (r_state == ST_REDIRECT);
   assign redirect_pc    = r_redirect_pc;
   assign busy           = (r_state != ST_IDLE);
   assign hazard_timeout = r_timeout;

`ifdef BRANCH_DELAY_SLOT_EN
   // The redirect-cycle instruction is the delay slot and must execute.
   assign flush_decode = 1'b0;
`else
   assign flush_decode = (r_state == ST_REDIRECT);
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_redirect_ctrl.sv
`default_nettype none
// Self-checking bench for branch_redirect_ctrl: directed vector table,
// hand-written reset/timeout sequences and randomized traffic vs. a model.
module tb_branch_redirect_ctrl;

   localparam int MAX_WAIT = 4;
   localparam int PC_WIDTH = 32;
`ifdef BRANCH_DELAY_SLOT_EN
   localparam bit DS = 1'b1;
`else
   localparam bit DS = 1'b0;
`endif

   logic                clock = 1'b0;
   logic                reset = 1'b1;
   logic                dv = 1'b0, ic = 1'b0, urs = 1'b0, urt = 1'b0;
   logic                rsp = 1'b0, rtp = 1'b0, pcs = 1'b0;
   logic [PC_WIDTH-1:0] ja = '0;
   logic                stall_fetch, stall_decode, flush_decode, redirect_valid;
   logic                busy, hazard_timeout;
   logic [PC_WIDTH-1:0] redirect_pc;

   branch_redirect_ctrl #(.MAX_WAIT(MAX_WAIT), .PC_WIDTH(PC_WIDTH)) dut (
      .clock(clock), .reset(reset),
      .dec_valid(dv), .dec_is_ctrl(ic), .dec_uses_rs(urs), .dec_uses_rt(urt),
      .rs_pending(rsp), .rt_pending(rtp), .pc_src(pcs), .jump_address(ja),
      .stall_fetch(stall_fetch), .stall_decode(stall_decode),
      .flush_decode(flush_decode), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .busy(busy), .hazard_timeout(hazard_timeout)
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: length of the current operand-wait run, a pending
   // redirect, the sticky timeout and the last taken target.
   bit                  m_live, m_fire, m_to;
   int                  m_run;
   logic [PC_WIDTH-1:0] m_pc;

   typedef struct {
      bit                  dv, ic, urs, urt, rsp, rtp, pcs;
      logic [PC_WIDTH-1:0] ja;
      bit                  st, rv, bs, to;
      logic [PC_WIDTH-1:0] pc;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(bit a, bit b, bit c, bit d, bit e, bit f, bit g,
                               logic [PC_WIDTH-1:0] j, bit st, bit rv, bit bs,
                               bit to, logic [PC_WIDTH-1:0] pc);
      vec_t v;
      v.dv = a; v.ic = b; v.urs = c; v.urt = d; v.rsp = e; v.rtp = f; v.pcs = g;
      v.ja = j; v.st = st; v.rv = rv; v.bs = bs; v.to = to; v.pc = pc;
      return v;
   endfunction

   task automatic model_reset();
      m_live = 0; m_fire = 0; m_to = 0; m_run = 0; m_pc = '0;
   endtask

   task automatic drive(bit a, bit b, bit c, bit d, bit e, bit f, bit g,
                        logic [PC_WIDTH-1:0] j);
      dv = a; ic = b; urs = c; urt = d; rsp = e; rtp = f; pcs = g; ja = j;
   endtask

   task automatic set_reset(bit r);
      reset = r;
      if (r) model_reset();
   endtask

   task automatic model_step();
      bit need, active;
      if (reset) begin
         model_reset();
         return;
      end
      need = (urs & rsp) | (urt & rtp);
      if (!m_live) begin
         m_live = 1;
      end else if (m_fire) begin
         m_fire = 0;
      end else begin
         active = (m_run > 0) ? dv : (dv & ic);
         if (m_run > 0 && !dv) begin
            m_run = 0;
         end else if (active && need) begin
            m_run++;
            if (m_run >= MAX_WAIT) m_to = 1;
         end else if (active) begin
            m_run = 0;
            if (pcs) begin
               m_fire = 1;
               m_pc   = ja;
            end
         end
      end
   endtask

   task automatic cmp(string nm, bit e_st, bit e_rv, bit e_bs, bit e_to,
                      logic [PC_WIDTH-1:0] e_pc);
      logic [PC_WIDTH+5:0] act, exp;
      act = {stall_fetch, stall_decode, redirect_valid, flush_decode, busy,
             hazard_timeout, redirect_pc};
      exp = {e_st, e_st, e_rv, e_rv & ~DS, e_bs, e_to, e_pc};
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s t=%0t: got sf=%b sd=%b rv=%b fl=%b busy=%b to=%b pc=%h, want sf=%b sd=%b rv=%b fl=%b busy=%b to=%b pc=%h",
                  nm, $time, act[37], act[36], act[35], act[34], act[33], act[32], act[31:0],
                  exp[37], exp[36], exp[35], exp[34], exp[33], exp[32], exp[31:0]);
      end
   endtask

   task automatic model_check(string nm);
      bit e_st, e_rv, e_bs, need;
      need = (urs & rsp) | (urt & rtp);
      e_st = 0; e_rv = 0; e_bs = 0;
      if (!reset && m_live) begin
         if (m_fire) begin
            e_rv = 1; e_bs = 1;
         end else if (m_run > 0) begin
            e_bs = 1; e_st = dv & need;
         end else begin
            e_st = dv & ic & need;
         end
      end
      cmp(nm, e_st, e_rv, e_bs, m_to, m_pc);
   endtask

   // Inputs are already driven (1 time unit after a rising edge); outputs are
   // checked on the falling edge, then the model advances on the next edge.
   task automatic run_cycle(bit use_model, string nm, bit e_st, bit e_rv,
                            bit e_bs, bit e_to, logic [PC_WIDTH-1:0] e_pc);
      @(negedge clock);
      if (use_model) model_check(nm);
      else cmp(nm, e_st, e_rv, e_bs, e_to, e_pc);
      @(posedge clock);
      model_step();
      #1;
   endtask

   initial begin
      // dv ic urs urt rsp rtp pcs ja | stall rv busy to redirect_pc
      tbl.push_back(mk(1,1,0,0,0,0,1,32'h0040_0100, 0,0,0,0,32'h0));
      tbl.push_back(mk(1,1,0,0,0,0,1,32'h1234_5678, 0,1,1,0,32'h0040_0100));
      tbl.push_back(mk(0,0,0,0,0,0,0,32'h0,         0,0,0,0,32'h0040_0100));
      tbl.push_back(mk(1,1,0,0,0,0,0,32'hDEAD_BEEF, 0,0,0,0,32'h0040_0100));
      tbl.push_back(mk(1,1,0,0,0,0,0,32'hDEAD_BEEF, 0,0,0,0,32'h0040_0100));
      tbl.push_back(mk(1,1,1,0,1,0,1,32'hFFFF_0000, 1,0,0,0,32'h0040_0100));
      tbl.push_back(mk(1,1,1,0,1,0,1,32'hFFFF_0000, 1,0,1,0,32'h0040_0100));
      tbl.push_back(mk(1,1,1,0,1,0,1,32'hFFFF_0000, 1,0,1,0,32'h0040_0100));
      tbl.push_back(mk(1,1,1,0,0,0,1,32'h0000_2000, 0,0,1,0,32'h0040_0100));
      tbl.push_back(mk(0,0,0,0,0,0,0,32'h0,         0,1,1,0,32'h0000_2000));
      tbl.push_back(mk(0,0,0,0,0,0,0,32'h0,         0,0,0,0,32'h0000_2000));
      tbl.push_back(mk(1,1,0,1,0,1,0,32'h0,         1,0,0,0,32'h0000_2000));
      tbl.push_back(mk(1,1,0,1,0,1,0,32'h0,         1,0,1,0,32'h0000_2000));
      tbl.push_back(mk(1,1,0,1,0,1,0,32'h0,         1,0,1,0,32'h0000_2000));
      tbl.push_back(mk(1,1,0,1,0,1,0,32'h0,         1,0,1,0,32'h0000_2000));
      tbl.push_back(mk(1,1,0,1,0,1,0,32'h0,         1,0,1,1,32'h0000_2000));
      tbl.push_back(mk(1,1,0,1,0,1,0,32'h0,         1,0,1,1,32'h0000_2000));
      tbl.push_back(mk(1,1,0,1,0,0,0,32'h0,         0,0,1,1,32'h0000_2000));
      tbl.push_back(mk(0,0,0,0,0,0,0,32'h0,         0,0,0,1,32'h0000_2000));
      tbl.push_back(mk(1,1,1,0,1,0,1,32'h0,         1,0,0,1,32'h0000_2000));
      tbl.push_back(mk(0,0,1,0,1,0,1,32'h0,         0,0,1,1,32'h0000_2000));
      tbl.push_back(mk(0,0,0,0,0,0,0,32'h0,         0,0,0,1,32'h0000_2000));
      tbl.push_back(mk(1,1,0,0,1,0,1,32'h0000_0ABC, 0,0,0,1,32'h0000_2000));
      tbl.push_back(mk(0,0,0,0,0,0,0,32'h0,         0,1,1,1,32'h0000_0ABC));
      tbl.push_back(mk(0,0,0,0,0,0,0,32'h0,         0,0,0,1,32'h0000_0ABC));
      tbl.push_back(mk(1,0,1,0,1,0,1,32'h0,         0,0,0,1,32'h0000_0ABC));

      model_reset();
      drive(0,0,0,0,0,0,0,'0);
      repeat (2) @(posedge clock);
      #1;

      // Reset held with a stalling branch present, then the first free cycle.
      drive(1,1,1,0,1,0,0,'0);
      run_cycle(0, "reset_held", 0,0,0,0,'0);
      set_reset(0);
      run_cycle(0, "first_after_release", 0,0,0,0,'0);

      foreach (tbl[i]) begin
         drive(tbl[i].dv, tbl[i].ic, tbl[i].urs, tbl[i].urt, tbl[i].rsp,
               tbl[i].rtp, tbl[i].pcs, tbl[i].ja);
         run_cycle(0, $sformatf("tbl[%0d]", i), tbl[i].st, tbl[i].rv,
                   tbl[i].bs, tbl[i].to, tbl[i].pc);
      end

      // Reset asserted in the second WAIT_OPS cycle; also clears the sticky flag.
      drive(1,1,1,0,1,0,1,32'h5555_0000);
      run_cycle(0, "rst_seq_enter", 1,0,0,1,32'h0000_0ABC);
      run_cycle(0, "rst_seq_wait1", 1,0,1,1,32'h0000_0ABC);
      set_reset(1);
      #1;
      cmp("rst_seq_async", 0,0,0,0,'0);
      run_cycle(0, "rst_seq_wait2", 0,0,0,0,'0);
      set_reset(0);
      run_cycle(0, "rst_seq_release", 0,0,0,0,'0);
      run_cycle(0, "rst_seq_idle_stall", 1,0,0,0,'0);
      drive(0,0,0,0,0,0,0,'0);
      run_cycle(0, "rst_seq_flush", 0,0,1,0,'0);
      run_cycle(0, "rst_seq_quiet", 0,0,0,0,'0);

      // Randomized traffic against the model, with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         drive($urandom_range(0,9) < 8, $urandom_range(0,9) < 6,
               $urandom_range(0,1) == 1, $urandom_range(0,1) == 1,
               $urandom_range(0,9) < 5, $urandom_range(0,9) < 5,
               $urandom_range(0,1) == 1, $urandom);
         set_reset($urandom_range(0,99) == 0);
         run_cycle(1, $sformatf("rand[%0d]", i), 0,0,0,0,'0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got no end, want end");
      $fatal(1);
   end

endmodule
`default_nettype wire
